// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: one start bit, DATA_W data bits LSB first,
// optional even/odd parity and STOP_BITS stop bits. Each bit lasts one tick
// period, and frames are aligned to the tick grid through an ALIGN state.
module tick_uart_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SCNT_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic        ODD    = 1'(PARITY == 2);
  localparam logic        HAS_PAR = 1'(PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // State and output registers; reset parks the line high and drops tx_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Frame sequencing; outside IDLE every transition is gated by tick.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (tick) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q < CNT_W'(DATA_W - 1)) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            tx_d    = shift_q[1];
          end else if (HAS_PAR) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            scnt_d  = '0;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          scnt_d  = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (scnt_q == SCNT_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
